spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter MODE, default 0, meaning SPI mode 0-3, with CPOL=MODE[1] and CPHA=MODE[0].
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning bits per frame, legal range 4-32.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, one clock, all logic rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port sclk, input, 1 bit: SPI clock from master, asynchronous to clk.
REQ-006 The block SHALL have port ss_n, input, 1 bit: slave select, active-low, asynchronous to clk.
REQ-007 The block SHALL have port mosi, input, 1 bit: serial data from master.
REQ-008 The block SHALL have port miso, output, 1 bit: serial data to master, registered.
REQ-009 The block SHALL have port miso_oe, output, 1 bit: miso drive enable; high only while synchronized ss_n is low.
REQ-010 The block SHALL have port tx_data, input, DATA_WIDTH bits: next word to return to master.
REQ-011 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-012 The block SHALL have port tx_ready, output, 1 bit: transmit holding buffer is empty.
REQ-013 The block SHALL have port rx_data, output, DATA_WIDTH bits: last complete received word.
REQ-014 The block SHALL have port rx_valid, output, 1 bit: one-clk pulse when rx_data updates.
REQ-015 The block SHALL have port busy, output, 1 bit: frame in progress (synchronized ss_n low).
REQ-016 The block SHALL have port tx_underrun, output, 1 bit: one-clk pulse when a word is loaded while the buffer is empty.

Function
REQ-017 sclk, ss_n and mosi SHALL each pass through a 2-FF synchronizer; sclk edges SHALL be detected on the synchronized copy; every internal action therefore occurs 3 clk cycles after the pin event.
REQ-018 The master sclk high and low phases SHALL each be at least 4 clk periods; behaviour below this is unspecified.
REQ-019 The FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on synchronized ss_n falling; ACTIVE->IDLE on synchronized ss_n rising.
REQ-020 A tx_valid&&tx_ready handshake SHALL latch tx_data into the holding buffer and drop tx_ready the next cycle; tx_ready SHALL rise the cycle after the buffer is moved to the shift register.
REQ-021 Word load SHALL occur on entry to ACTIVE and, with ss_n still low, in the same cycle as rx_valid; the source is the buffer if full, else all-zeros with tx_underrun pulsed.
REQ-022 The leading edge SHALL be the sclk transition away from CPOL; the trailing edge SHALL be the transition back to CPOL.
REQ-023 When CPHA=0, miso SHALL present the MSB one cycle after load, mosi SHALL be sampled on leading edges, and the shift register SHALL advance on trailing edges.
REQ-024 When CPHA=1, miso SHALL update on leading edges and mosi SHALL be sampled on trailing edges.
REQ-025 Transfers SHALL be MSB first in both directions.
REQ-026 The bit counter SHALL wrap at DATA_WIDTH sample edges; on the final sample, rx_data SHALL update and rx_valid SHALL pulse for exactly 1 clk.
REQ-027 Back-to-back frames under a continuous ss_n low SHALL be supported with no gap.
REQ-028 When ss_n rises mid-word, the partial word SHALL be discarded, with no rx_valid, the bit counter cleared, and the holding buffer kept.
REQ-029 When a handshake coincides with a load, the loaded word SHALL be the buffer's prior content if the buffer was full; if the buffer was empty, the load SHALL be zeros with tx_underrun, and the new data SHALL be retained for the next word.
REQ-030 sclk edges while ss_n is high SHALL be ignored.
REQ-031 When miso_oe is low, miso SHALL be 0.

Reset
REQ-032 When rst_n is low, the block SHALL be in state IDLE, miso=0, miso_oe=0, tx_ready=1, buffer empty, rx_data=0, rx_valid=0, busy=0, tx_underrun=0, and synchronizers cleared.
REQ-033 A reset mid-frame SHALL abort the frame immediately; after release, the block SHALL wait for a fresh ss_n falling edge before entering ACTIVE.

Verification
REQ-034 Mode 0, buffer preloaded with 0x3C, master sends 0xA5 -> rx_data=0xA5, one rx_valid pulse, miso carries 0x3C MSB first, tx_ready rises after the load.
REQ-035 Each of modes 1, 2 and 3: master sends 0xCC with buffer holding 0x5A -> rx_data=0xCC and master receives 0x5A.
REQ-036 ss_n low for 3 words 0x00, 0x11, 0x22 with buffer refilled on each tx_ready -> three rx_valid pulses in order, no tx_underrun.
REQ-037 Frame with empty buffer, master sends 0x12 -> tx_underrun pulse, miso all zeros, rx_data=0x12.
REQ-038 ss_n raised after 5 bits, then full frame 0x81 -> no rx_valid for the aborted frame, rx_data=0x81 afterwards.
REQ-039 rst_n asserted mid-frame -> all outputs at reset values within one cycle; the next full frame is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave with a one-word transmit holding buffer.
// All four SPI modes are supported. The SPI pins are sampled into the clk domain through
// 2-FF synchronizers, and every action is taken on the synchronized copies.
module spi_slave #(
  parameter int unsigned MODE       = 0,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam bit          Cpol = MODE[1];
  localparam bit          Cpha = MODE[0];
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StActive = 1'b1;

  // Synchronizer stages; the third sclk/ss_n stage is only used for edge detection
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic ss_s1_q, ss_s2_q, ss_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  logic [0:0]            state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  underrun_q, underrun_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic ss_fall, in_frame, sample_edge, shift_edge, final_sample, load;

  // Pin synchronizers. sclk resets to its idle level so that release of reset cannot create a
  // phantom edge. ss_n resets low, so a frame can only start on a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q <= Cpol;
      sclk_s2_q <= Cpol;
      sclk_s3_q <= Cpol;
      ss_s1_q   <= 1'b0;
      ss_s2_q   <= 1'b0;
      ss_s3_q   <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      ss_s1_q   <= ss_n;
      ss_s2_q   <= ss_s1_q;
      ss_s3_q   <= ss_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  // Edge decode on the synchronized copies
  always_comb begin
    sclk_rise    = sclk_s2_q & ~sclk_s3_q;
    sclk_fall    = ~sclk_s2_q & sclk_s3_q;
    lead_edge    = Cpol ? sclk_fall : sclk_rise;
    trail_edge   = Cpol ? sclk_rise : sclk_fall;
    ss_fall      = ss_s3_q & ~ss_s2_q;
    in_frame     = (state_q == StActive) && !ss_s2_q;
    sample_edge  = in_frame && (Cpha ? trail_edge : lead_edge);
    shift_edge   = in_frame && (Cpha ? lead_edge : trail_edge);
    final_sample = sample_edge && (bit_cnt_q == CntW'(DATA_WIDTH - 1));
    load         = ((state_q == StIdle) && ss_fall) || final_sample;
  end

  // Next-state logic: FSM, bit counter, shift registers and the holding buffer
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_shift_d = tx_shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    underrun_d = 1'b0;
    miso_d     = miso_q;

    case (state_q)
      StIdle:   if (ss_fall) state_d = StActive;
      StActive: if (ss_s2_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // A deselect mid-word throws the partial word away
    if ((state_q == StActive) && ss_s2_q) bit_cnt_d = '0;

    if (sample_edge) begin
      rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2_q};
      if (final_sample) begin
        bit_cnt_d  = '0;
        rx_data_d  = rx_shift_d;
        rx_valid_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CntW'(1);
      end
    end

    if (shift_edge) begin
      if (Cpha) begin
        miso_d     = tx_shift_q[DATA_WIDTH-1];
        tx_shift_d = tx_shift_q << 1;
      end else if (bit_cnt_q != '0) begin
        // With CPHA=0 the word is reloaded on the last leading edge; the trailing edge that
        // follows it (counter back at zero) must not shift the new MSB away.
        tx_shift_d = tx_shift_q << 1;
      end
    end

    if (load) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end

    // Handshake only while empty, so a coinciding load has already chosen zeros
    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    if (!Cpha) miso_d = tx_shift_q[DATA_WIDTH-1];

    // ss_s1 is next cycle's ss_s2, so the enable never outlives a synchronized deselect
    miso_oe_d = (state_d == StActive) && !ss_s1_q;
    if (!miso_oe_d) miso_d = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_shift_q <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_shift_q <= tx_shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      underrun_q <= underrun_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign busy        = miso_oe_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule
